// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared widths, state encoding and round-robin search for SDRAM port arbiters
package sdram_arb_pkg;

   localparam int ADDR_W    = 22;
   localparam int DATA_W    = 32;
   localparam int MASK_W    = 4;
   localparam int MAX_PORTS = 8;

   typedef enum logic [1:0] {
      ARB     = 2'd0,
      ISSUE   = 2'd1,
      RECOVER = 2'd2
   } arb_state_t;

   // First set bit of valid scanning last+1, last+2, ... modulo n; returns last when none is set.
   function automatic logic [2:0] rr_first(input logic [MAX_PORTS-1:0] valid,
                                           input logic [2:0] last,
                                           input int n);
      int   j;
      logic found;
      found    = 1'b0;
      rr_first = last;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         j = (int'({1'b0, last}) + k) % n;
         if (!found && (k <= n) && valid[3'(j)]) begin
            found    = 1'b1;
            rr_first = 3'(j);
         end
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection for a valid vector
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int GW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] valid,
   input  logic [GW-1:0]        last_grant,
   output logic [GW-1:0]        winner,
   output logic                 any_valid
);

   logic [MAX_PORTS-1:0] valid_ext;
   logic [2:0]           pick;

   assign valid_ext = MAX_PORTS'(valid);
   assign pick      = rr_first(valid_ext, 3'(last_grant), NUM_PORTS);
   assign winner    = GW'(pick);
   assign any_valid = |valid;

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM controller port with optional bounded lock
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int MAX_LOCK  = 4,
   localparam int GW       = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS-1:0]        req_lock,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] req_din,
   input  logic [NUM_PORTS*MASK_W-1:0] req_wmask,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic [DATA_W-1:0]           req_dout,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_din,
   output logic [MASK_W-1:0]           mem_wmask,
   output logic                        mem_valid,
   input  logic [DATA_W-1:0]           mem_dout,
   input  logic                        mem_ready,
   output logic [GW-1:0]               grant_id,
   output logic                        busy
);

   localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

   arb_state_t    state;
   logic [GW-1:0] last_grant;
   logic [3:0]    lock_cnt;
   logic          lock_active;
   logic [GW-1:0] rr_winner;
   logic [GW-1:0] winner;
   logic          any_valid;
   logic          lock_hit;

   rr_pick #(
      .NUM_PORTS(NUM_PORTS),
      .GW       (GW)
   ) u_rr_pick (
      .valid     (req_valid),
      .last_grant(last_grant),
      .winner    (rr_winner),
      .any_valid (any_valid)
   );

   // A held lock overrides round-robin only while the locked port still requests.
   assign lock_hit = lock_active && req_valid[grant_id];
   assign winner   = lock_hit ? grant_id : rr_winner;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ARB;
         last_grant  <= LAST_PORT;
         lock_cnt    <= 4'd0;
         lock_active <= 1'b0;
         req_ready   <= '0;
         req_dout    <= '0;
         mem_addr    <= '0;
         mem_din     <= '0;
         mem_wmask   <= '0;
         mem_valid   <= 1'b0;
         grant_id    <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ARB: begin
               if (any_valid) begin
                  if (lock_active && !req_valid[grant_id]) begin
                     lock_active <= 1'b0;
                     lock_cnt    <= 4'd0;
                  end
                  mem_addr   <= req_addr[winner*ADDR_W +: ADDR_W];
                  mem_din    <= req_din[winner*DATA_W +: DATA_W];
                  mem_wmask  <= req_wmask[winner*MASK_W +: MASK_W];
                  mem_valid  <= 1'b1;
                  grant_id   <= winner;
                  last_grant <= winner;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  req_dout  <= mem_dout;
                  req_ready <= NUM_PORTS'(1) << grant_id;
                  mem_valid <= 1'b0;
                  state     <= RECOVER;
                  if (req_lock[grant_id] && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
                     lock_active <= 1'b1;
                     lock_cnt    <= lock_cnt + 4'd1;
                  end else begin
                     lock_active <= 1'b0;
                     lock_cnt    <= 4'd0;
                  end
               end
            end
            RECOVER: begin
               req_ready <= '0;
               busy      <= 1'b0;
               state     <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

   localparam int NP = 3;

   logic             clk = 1'b0;
   logic             resetn;
   logic [NP-1:0]    req_valid;
   logic [NP-1:0]    req_lock;
   logic [NP*22-1:0] req_addr;
   logic [NP*32-1:0] req_din;
   logic [NP*4-1:0]  req_wmask;
   logic [NP-1:0]    req_ready;
   logic [31:0]      req_dout;
   logic [21:0]      mem_addr;
   logic [31:0]      mem_din;
   logic [3:0]       mem_wmask;
   logic             mem_valid;
   logic [31:0]      mem_dout = '0;
   logic             mem_ready;
   logic [1:0]       grant_id;
   logic             busy;

   logic             model_ready = 1'b0;
   logic             spur_ready;
   int               model_cnt = 0;
   int               model_lat;
   logic [31:0]      rd_data;
   int               ready_cnt [NP] = '{default: 0};
   int               checks = 0;
   int               errors = 0;

   sdram_port_arbiter #(
      .NUM_PORTS(NP),
      .MAX_LOCK (4)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req_valid(req_valid),
      .req_lock (req_lock),
      .req_addr (req_addr),
      .req_din  (req_din),
      .req_wmask(req_wmask),
      .req_ready(req_ready),
      .req_dout (req_dout),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_wmask(mem_wmask),
      .mem_valid(mem_valid),
      .mem_dout (mem_dout),
      .mem_ready(mem_ready),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   assign mem_ready = model_ready | spur_ready;

   // Controller model: ready pulse model_lat negedges after valid is first seen.
   always @(negedge clk) begin
      if (!resetn) begin
         model_ready = 1'b0;
         model_cnt   = 0;
      end else if (model_ready) begin
         model_ready = 1'b0;
      end else if (mem_valid) begin
         if (model_cnt >= model_lat - 1) begin
            model_ready = 1'b1;
            mem_dout    = rd_data;
            model_cnt   = 0;
         end else begin
            model_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         for (int i = 0; i < NP; i++) begin
            if (req_ready[i]) ready_cnt[i]++;
         end
      end
   end

   task automatic set_port(input int p, input logic [21:0] a, input logic [31:0] d, input logic [3:0] m);
      req_addr[p*22 +: 22] = a;
      req_din[p*32 +: 32]  = d;
      req_wmask[p*4 +: 4]  = m;
   endtask

   task automatic wait_ready(input int budget, output logic [NP-1:0] rdy);
      rdy = '0;
      for (int i = 0; i < budget && rdy == '0; i++) begin
         @(negedge clk);
         rdy = req_ready;
      end
   endtask

   task automatic wait_mem_valid(input int budget, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = mem_valid;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_addr !== 22'h0 || req_dout !== 32'h0) begin
         errors++; $display("FAIL reset_data got addr %h dout %h want 0 0", mem_addr, req_dout);
      end
   endtask

   task automatic test_single();
      logic [NP-1:0] rdy;
      int            n;
      model_lat = 12;
      rd_data   = 32'hDEADBEEF;
      set_port(1, 22'h12345, 32'h0, 4'b0000);
      req_valid = 3'b010;
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 22'h12345 || mem_wmask !== 4'b0000) begin
         errors++; $display("FAIL single_issue got valid %b addr %h wmask %b want 1 12345 0000", mem_valid, mem_addr, mem_wmask);
      end
      checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL single_grant got id %0d busy %b want 1 1", grant_id, busy);
      end
      n   = 0;
      rdy = '0;
      while (rdy == '0 && n < 100) begin
         @(negedge clk);
         n++;
         rdy = req_ready;
      end
      req_valid = 3'b000;
      checks++; if (rdy !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", rdy); end
      checks++; if (n !== 12) begin errors++; $display("FAIL single_latency got %0d want 12", n); end
      checks++; if (req_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dout got %h want deadbeef", req_dout); end
      @(negedge clk);
      checks++; if (req_ready !== 3'b000 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL single_pulse_width got ready %b valid %b want 000 0", req_ready, mem_valid);
      end
   endtask

   task automatic test_fairness();
      logic [NP-1:0] rdy;
      logic [NP-1:0] exp;
      do_reset();
      model_lat = 2;
      rd_data   = 32'h1234_5678;
      for (int p = 0; p < NP; p++) set_port(p, 22'h100 + 22'(p), 32'h0, 4'b0000);
      req_lock  = '0;
      req_valid = 3'b111;
      for (int k = 0; k < 9; k++) begin
         exp = 3'b001 << (k % 3);
         wait_ready(200, rdy);
         checks++; if (rdy !== exp) begin errors++; $display("FAIL fair_order_%0d got %b want %b", k, rdy, exp); end
      end
      req_valid = 3'b000;
      checks++; if (req_dout !== 32'h1234_5678) begin errors++; $display("FAIL fair_dout got %h want 12345678", req_dout); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_lock();
      logic [NP-1:0] rdy;
      logic [NP-1:0] exp_seq [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
      model_lat = 3;
      req_valid = 3'b010;
      wait_ready(200, rdy);
      checks++; if (rdy !== 3'b010) begin errors++; $display("FAIL lock_setup got %b want 010", rdy); end
      req_lock  = 3'b100;
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         wait_ready(200, rdy);
         checks++; if (rdy !== exp_seq[k]) begin errors++; $display("FAIL lock_order_%0d got %b want %b", k, rdy, exp_seq[k]); end
      end
      req_valid = 3'b000;
      req_lock  = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write();
      logic [NP-1:0] rdy;
      logic          seen;
      int            unstable;
      model_lat = 5;
      set_port(0, 22'h00ABC, 32'hA5A5_5A5A, 4'b0011);
      req_valid = 3'b001;
      wait_mem_valid(50, seen);
      checks++; if (!seen || mem_din !== 32'hA5A5_5A5A || mem_wmask !== 4'b0011 || mem_addr !== 22'h00ABC) begin
         errors++; $display("FAIL write_fields got valid %b din %h wmask %b addr %h want 1 a5a55a5a 0011 00abc", seen, mem_din, mem_wmask, mem_addr);
      end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL write_grant got %0d want 0", grant_id); end
      set_port(0, 22'h3FFFF, 32'h0F0F_0F0F, 4'b1100);
      unstable = 0;
      rdy      = '0;
      for (int i = 0; i < 50 && rdy == '0; i++) begin
         if (mem_din !== 32'hA5A5_5A5A || mem_wmask !== 4'b0011 || mem_addr !== 22'h00ABC) unstable++;
         @(negedge clk);
         rdy = req_ready;
      end
      req_valid = 3'b000;
      checks++; if (unstable !== 0) begin errors++; $display("FAIL write_stable got %0d unstable cycles want 0", unstable); end
      checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL write_ready got %b want 001", rdy); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_spurious();
      logic [NP-1:0] rdy;
      int            before1;
      int            before0;
      spur_ready = 1'b1;
      @(negedge clk);
      spur_ready = 1'b0;
      checks++; if (req_ready !== 3'b000 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL spurious_ready got ready %b valid %b want 000 0", req_ready, mem_valid);
      end
      @(negedge clk);
      checks++; if (req_ready !== 3'b000 || busy !== 1'b0) begin
         errors++; $display("FAIL spurious_late got ready %b busy %b want 000 0", req_ready, busy);
      end
      model_lat = 10;
      before0   = ready_cnt[0];
      before1   = ready_cnt[1];
      set_port(0, 22'h00010, 32'h0, 4'b0000);
      set_port(1, 22'h00020, 32'h0, 4'b0000);
      req_valid = 3'b001;
      @(negedge clk);
      req_valid = 3'b011;
      repeat (3) @(negedge clk);
      req_valid = 3'b001;
      wait_ready(100, rdy);
      req_valid = 3'b000;
      checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL abort_port0 got %b want 001", rdy); end
      repeat (20) @(negedge clk);
      checks++; if (ready_cnt[1] !== before1 || ready_cnt[0] !== before0 + 1) begin
         errors++; $display("FAIL abort_counts got p0 %0d p1 %0d want %0d %0d", ready_cnt[0], ready_cnt[1], before0 + 1, before1);
      end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", mem_valid); end
   endtask

   task automatic test_reset_mid();
      logic [NP-1:0] rdy;
      logic          seen;
      int            before2;
      model_lat = 12;
      before2   = ready_cnt[2];
      set_port(0, 22'h00111, 32'h0, 4'b0000);
      set_port(2, 22'h00222, 32'h0, 4'b0000);
      req_valid = 3'b100;
      wait_mem_valid(50, seen);
      checks++; if (!seen || grant_id !== 2'd2) begin errors++; $display("FAIL midrst_setup got valid %b id %0d want 1 2", seen, grant_id); end
      repeat (3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++; if (mem_valid !== 1'b0 || req_ready !== 3'b000) begin
         errors++; $display("FAIL midrst_async got valid %b ready %b want 0 000", mem_valid, req_ready);
      end
      checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin
         errors++; $display("FAIL midrst_state got busy %b id %0d want 0 0", busy, grant_id);
      end
      req_valid = 3'b111;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 22'h00111) begin
         errors++; $display("FAIL midrst_priority got valid %b id %0d addr %h want 1 0 00111", mem_valid, grant_id, mem_addr);
      end
      wait_ready(100, rdy);
      req_valid = 3'b000;
      checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL midrst_ready got %b want 001", rdy); end
      checks++; if (ready_cnt[2] !== before2) begin errors++; $display("FAIL midrst_abandon got %0d want %0d", ready_cnt[2], before2); end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      resetn     = 1'b0;
      req_valid  = '0;
      req_lock   = '0;
      req_addr   = '0;
      req_din    = '0;
      req_wmask  = '0;
      spur_ready = 1'b0;
      model_lat  = 4;
      rd_data    = '0;
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_write();
      test_spurious();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Round-robin arbiter sharing one w9864g6jt SDRAM controller port between NUM_PORTS requesters (CPU, DMA, video fetch and similar).
Requesters use the same addr/din/wmask/valid/dout/ready handshake as the controller. The arbiter registers the winning request and drives the controller. It returns read data and a one-cycle ready pulse to the granted port only.
An optional per-port lock keeps the grant across back-to-back accesses, for example read-modify-write, with a bounded burst count.

Parameters:
NUM_PORTS, 3, number of requesters (2..8).
MAX_LOCK, 4, maximum consecutive grants to one port while it holds req_lock (1..15).

Ports:
clk  in  1  system clock, same clock as the SDRAM controller.
resetn  in  1  reset, asynchronous, active-low.
req_valid  in  NUM_PORTS  per-port request valid.
req_lock  in  NUM_PORTS  per-port lock request, sampled on that port's ready cycle.
req_addr  in  NUM_PORTS*22  per-port word address; port i occupies bits [22*i+21:22*i].
req_din  in  NUM_PORTS*32  per-port write data.
req_wmask  in  NUM_PORTS*4  per-port byte write mask; all zero means read.
req_ready  out  NUM_PORTS  one-hot one-cycle completion pulse.
req_dout  out  32  read data, valid while req_ready is nonzero.
mem_addr  out  22  to controller addr.
mem_din  out  32  to controller din.
mem_wmask  out  4  to controller wmask.
mem_valid  out  1  to controller valid.
mem_dout  in  32  from controller dout.
mem_ready  in  1  from controller one-cycle ready pulse.
grant_id  out  clog2(NUM_PORTS)  index of the port currently or last granted.
busy  out  1  high in ISSUE and RECOVER.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: state=ARB; all outputs 0; last_grant=NUM_PORTS-1 so port 0 wins first; lock_cnt=0; lock_active=0.
- The controller is reset by the same resetn. Reset mid-transaction abandons the transfer and no req_ready pulse is emitted.
- All outputs are registered. There is no combinational path from req_* or mem_* to any output.
- ARB state:
  - If no req_valid bit is set, stay in ARB with mem_valid=0.
  - Otherwise pick a winner. If lock_active and req_valid[grant_id], the winner is grant_id. If lock_active and the locked port is not valid, clear lock_active and lock_cnt and use round-robin.
  - Round-robin picks the first valid port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Register the winner's addr, din and wmask into mem_*. Set mem_valid=1, grant_id=winner, last_grant=winner, then go to ISSUE.
  - Latency: req_valid seen at edge t gives mem_valid=1 after edge t.
- ISSUE state:
  - mem_* are held stable. Changes on req_* are ignored.
  - When mem_ready=1: req_dout<=mem_dout (also on writes), req_ready[grant_id]<=1 for exactly one cycle, mem_valid<=0, go to RECOVER.
  - Lock update in the same cycle:
    - If req_lock[grant_id] and lock_cnt+1<MAX_LOCK: lock_active=1, lock_cnt+=1.
    - Else: lock_active=0, lock_cnt=0.
  - There is no timeout; ISSUE waits indefinitely because controller refresh cycles add variable latency.
- RECOVER state: one cycle with mem_valid=0 and req_ready cleared, then go to ARB. This gives the requester one cycle to drop or replace req_valid, and satisfies the controller's requirement that valid is not re-sampled while its ready is high.
- mem_ready outside ISSUE is ignored and produces no req_ready.
- Requester rule: hold req_valid and its fields until req_ready. A requester that drops req_valid before it is granted loses its request with no side effect.
- Best-case back-to-back throughput: one transfer per (controller latency + 2) cycles.

Decomposition:
- Package sdram_arb_pkg:
  - ADDR_W=22, DATA_W=32, MASK_W=4.
  - State encoding ARB/ISSUE/RECOVER (2 bits).
  - Function for the rotate-and-find-first index.
- Sub-module rr_pick: combinational, input valid vector and last_grant, output winner index and any_valid. It is reused by other shared-resource arbiters.

Test Plan:
- Single port: port1 read addr 22'h12345, bench controller model returns 32'hDEADBEEF after 12 cycles -> mem_addr=22'h12345 and wmask=0 one cycle after valid; req_ready=3'b010 exactly one cycle; req_dout=32'hDEADBEEF.
- Fairness: all 3 ports continuously valid, no lock, 9 transfers -> grant order 0,1,2,0,1,2,0,1,2.
- Lock limit: port2 holds req_lock=1 and stays valid, ports 0 and 1 also valid, MAX_LOCK=4 -> four consecutive port2 grants, then port0, then port1.
- Write mask passthrough: port0 writes din=32'hA5A5_5A5A, wmask=4'b0011 -> mem_din and mem_wmask match and stay stable throughout ISSUE; the req_dout value is don't-care.
- Spurious and abort cases:
  - mem_ready pulsed while in ARB -> no req_ready.
  - Port1 drops valid before its grant -> it is never granted.
- Reset mid-ISSUE: assert resetn=0 asynchronously -> mem_valid=0 and req_ready=0 immediately; after release, port0 has priority again.
